// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, opcodes,
// prediction flag values, FSM state encoding and the next-PC predictor.
package inst_fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic JUMP     = 1'b1;
    localparam logic NOT_JUMP = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              pd;
    } pred_t;

    // Next fetch address and jump flag for a word fetched at pc.
    // JAL always jumps; a branch jumps only when the direction predictor
    // says taken; everything else (JALR included) falls through.
    function automatic pred_t predict_next(input logic [ADDR_W-1:0] pc,
                                           input logic [INST_W-1:0] inst,
                                           input logic              br_taken);
        logic signed [ADDR_W-1:0] imm_j;
        logic signed [ADDR_W-1:0] imm_b;
        pred_t                    r;
        imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        r.pc  = pc + 32'd4;
        r.pd  = NOT_JUMP;
        if (inst[6:0] == OP_JAL) begin
            r.pc = pc + imm_j;
            r.pd = JUMP;
        end else if (inst[6:0] == OP_BRANCH && br_taken) begin
            r.pc = pc + imm_b;
            r.pd = JUMP;
        end
        return r;
    endfunction

endpackage

// File: rtl/inst_fetch_branch_predictor.sv
// Branch history table: one 2-bit saturating counter per index.
// Lookup is combinational; updates land on the next edge, so a lookup of
// the index being updated in the same cycle returns the old counter.
module inst_fetch_branch_predictor #(
    parameter  int ENTRIES = 64,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             predict_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] counters [ENTRIES];

    assign predict_taken = counters[lookup_idx][1];

    // Saturating counter update from resolved branch outcomes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counters[i] <= 2'b01;
            end
        end else if (rdy && upd_en) begin
            if (upd_taken) begin
                if (counters[upd_idx] != 2'b11) begin
                    counters[upd_idx] <= counters[upd_idx] + 2'd1;
                end
            end else begin
                if (counters[upd_idx] != 2'b00) begin
                    counters[upd_idx] <= counters[upd_idx] - 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the fetch PC, requests words from the memory
// controller, predicts the next PC and hands each word to the decoder.
// Optional feature macro: IF_BHT_EN builds the branch history table;
// without it, conditional branches are always predicted not-taken.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0,
    parameter int                BHT_ENTRIES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic              oMC_en,
    output logic [ADDR_W-1:0] oMC_addr,
    input  logic              iMC_done,
    input  logic [INST_W-1:0] iMC_inst,
    input  logic              iDEC_stall,
    output logic              oDEC_en,
    output logic [INST_W-1:0] oDEC_inst,
    output logic [ADDR_W-1:0] oDEC_pc,
    output logic              oDEC_pd,
    input  logic              iROB_jump_en,
    input  logic [ADDR_W-1:0] iROB_jump_pc,
    input  logic              iROB_bp_en,
    input  logic [ADDR_W-1:0] iROB_bp_pc,
    input  logic              iROB_bp_taken
);

    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              bht_taken;
    pred_t             pred;

`ifdef IF_BHT_EN
    logic unused_bp;
    assign unused_bp = ^iROB_bp_pc;

    inst_fetch_branch_predictor #(
        .ENTRIES(BHT_ENTRIES)
    ) u_branch_predictor (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .lookup_idx   (pc[BHT_IDX_W+1:2]),
        .predict_taken(bht_taken),
        .upd_en       (iROB_bp_en),
        .upd_idx      (iROB_bp_pc[BHT_IDX_W+1:2]),
        .upd_taken    (iROB_bp_taken)
    );
`else
    logic unused_bp;
    assign unused_bp = ^{iROB_bp_en, iROB_bp_pc, iROB_bp_taken, pc[BHT_IDX_W+1:2]};
    assign bht_taken = 1'b0;
`endif

    // Next-PC prediction for the word currently returned by memory.
    always_comb begin
        pred = predict_next(pc, iMC_inst, bht_taken);
    end

    // Fetch FSM with registered memory and decoder outputs; a redirect
    // overrides everything else and cancels any pending decoder output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            oMC_en    <= 1'b0;
            oMC_addr  <= '0;
            oDEC_en   <= 1'b0;
            oDEC_inst <= '0;
            oDEC_pc   <= '0;
            oDEC_pd   <= NOT_JUMP;
        end else if (!rdy) begin
            oDEC_en <= 1'b0;
        end else begin
            oDEC_en <= 1'b0;
            if (iROB_jump_en) begin
                pc <= iROB_jump_pc;
                case (state)
                    FETCH: begin
                        if (iMC_done) begin
                            oMC_en   <= 1'b1;
                            oMC_addr <= iROB_jump_pc;
                        end else begin
                            // Request still in flight: its data must be dropped.
                            state <= DROP;
                        end
                    end
                    DROP: begin
                        if (iMC_done) begin
                            state    <= FETCH;
                            oMC_addr <= iROB_jump_pc;
                        end
                    end
                    default: begin
                        state    <= FETCH;
                        oMC_en   <= 1'b1;
                        oMC_addr <= iROB_jump_pc;
                    end
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        state    <= FETCH;
                        oMC_en   <= 1'b1;
                        oMC_addr <= pc;
                    end
                    FETCH: begin
                        if (iMC_done) begin
                            pc        <= pred.pc;
                            oDEC_inst <= iMC_inst;
                            oDEC_pc   <= pc;
                            oDEC_pd   <= pred.pd;
                            if (!iDEC_stall) begin
                                oDEC_en  <= 1'b1;
                                oMC_addr <= pred.pc;
                            end else begin
                                // Word stays parked on the decoder outputs.
                                state  <= HOLD;
                                oMC_en <= 1'b0;
                            end
                        end
                    end
                    HOLD: begin
                        if (!iDEC_stall) begin
                            oDEC_en  <= 1'b1;
                            state    <= FETCH;
                            oMC_en   <= 1'b1;
                            oMC_addr <= pc;
                        end
                    end
                    DROP: begin
                        if (iMC_done) begin
                            state    <= FETCH;
                            oMC_addr <= pc;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch. Inputs change and outputs are sampled
// on the falling clock edge; DUT registers update on the rising edge.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        oMC_en;
    logic [31:0] oMC_addr;
    logic        iMC_done = 1'b0;
    logic [31:0] iMC_inst = 32'h0;
    logic        iDEC_stall = 1'b0;
    logic        oDEC_en;
    logic [31:0] oDEC_inst;
    logic [31:0] oDEC_pc;
    logic        oDEC_pd;
    logic        iROB_jump_en = 1'b0;
    logic [31:0] iROB_jump_pc = 32'h0;
    logic        iROB_bp_en = 1'b0;
    logic [31:0] iROB_bp_pc = 32'h0;
    logic        iROB_bp_taken = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    inst_fetch #(
        .RESET_PC(32'h0),
        .BHT_ENTRIES(64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .oMC_en       (oMC_en),
        .oMC_addr     (oMC_addr),
        .iMC_done     (iMC_done),
        .iMC_inst     (iMC_inst),
        .iDEC_stall   (iDEC_stall),
        .oDEC_en      (oDEC_en),
        .oDEC_inst    (oDEC_inst),
        .oDEC_pc      (oDEC_pc),
        .oDEC_pd      (oDEC_pd),
        .iROB_jump_en (iROB_jump_en),
        .iROB_jump_pc (iROB_jump_pc),
        .iROB_bp_en   (iROB_bp_en),
        .iROB_bp_pc   (iROB_bp_pc),
        .iROB_bp_taken(iROB_bp_taken)
    );

    always #5 clk = ~clk;

    // Redirect while a word completes in the same cycle (word is discarded).
    task automatic goto_pc(input logic [31:0] target);
        iROB_jump_en = 1'b1;
        iROB_jump_pc = target;
        iMC_done     = 1'b1;
        iMC_inst     = 32'h0080006F;
        @(negedge clk);
        iROB_jump_en = 1'b0;
        iMC_done     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (oMC_en !== 1'b0) begin n_bad++; $display("FAIL rst_mc_en got %b want 0", oMC_en); end
        n_cmp++; if (oMC_addr !== 32'h0) begin n_bad++; $display("FAIL rst_mc_addr got %h want 0", oMC_addr); end
        n_cmp++; if (oDEC_en !== 1'b0) begin n_bad++; $display("FAIL rst_dec_en got %b want 0", oDEC_en); end
        n_cmp++; if (oDEC_inst !== 32'h0) begin n_bad++; $display("FAIL rst_dec_inst got %h want 0", oDEC_inst); end
        n_cmp++; if (oDEC_pc !== 32'h0) begin n_bad++; $display("FAIL rst_dec_pc got %h want 0", oDEC_pc); end
        n_cmp++; if (oDEC_pd !== 1'b0) begin n_bad++; $display("FAIL rst_dec_pd got %b want 0", oDEC_pd); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (oMC_en !== 1'b1) begin n_bad++; $display("FAIL idle_to_fetch_en got %b want 1", oMC_en); end
        n_cmp++; if (oMC_addr !== 32'h0) begin n_bad++; $display("FAIL idle_to_fetch_addr got %h want 0", oMC_addr); end
    endtask

    task automatic test_basic();
        iMC_done = 1'b1;
        iMC_inst = 32'h00000013;
        @(negedge clk);
        iMC_done = 1'b0;
        n_cmp++; if (oDEC_en !== 1'b1) begin n_bad++; $display("FAIL basic_en got %b want 1", oDEC_en); end
        n_cmp++; if (oDEC_inst !== 32'h13) begin n_bad++; $display("FAIL basic_inst got %h want 13", oDEC_inst); end
        n_cmp++; if (oDEC_pc !== 32'h0) begin n_bad++; $display("FAIL basic_pc got %h want 0", oDEC_pc); end
        n_cmp++; if (oDEC_pd !== 1'b0) begin n_bad++; $display("FAIL basic_pd got %b want 0", oDEC_pd); end
        n_cmp++; if (oMC_en !== 1'b1) begin n_bad++; $display("FAIL basic_mc_en got %b want 1", oMC_en); end
        n_cmp++; if (oMC_addr !== 32'h4) begin n_bad++; $display("FAIL basic_next_addr got %h want 4", oMC_addr); end
        @(negedge clk);
        n_cmp++; if (oDEC_en !== 1'b0) begin n_bad++; $display("FAIL basic_pulse got %b want 0", oDEC_en); end
    endtask

    task automatic test_jal();
        goto_pc(32'h10);
        n_cmp++; if (oDEC_en !== 1'b0) begin n_bad++; $display("FAIL redir_done_en got %b want 0", oDEC_en); end
        n_cmp++; if (oMC_addr !== 32'h10) begin n_bad++; $display("FAIL redir_done_addr got %h want 10", oMC_addr); end
        iMC_done = 1'b1;
        iMC_inst = 32'h0080006F;
        @(negedge clk);
        iMC_done = 1'b0;
        n_cmp++; if (oDEC_en !== 1'b1) begin n_bad++; $display("FAIL jal_en got %b want 1", oDEC_en); end
        n_cmp++; if (oDEC_pc !== 32'h10) begin n_bad++; $display("FAIL jal_pc got %h want 10", oDEC_pc); end
        n_cmp++; if (oDEC_pd !== 1'b1) begin n_bad++; $display("FAIL jal_pd got %b want 1", oDEC_pd); end
        n_cmp++; if (oMC_addr !== 32'h18) begin n_bad++; $display("FAIL jal_target got %h want 18", oMC_addr); end
    endtask

    task automatic test_stall();
        iDEC_stall = 1'b1;
        @(negedge clk);
        n_cmp++; if (oDEC_en !== 1'b0) begin n_bad++; $display("FAIL stall_pre_en got %b want 0", oDEC_en); end
        iMC_done = 1'b1;
        iMC_inst = 32'h00100093;
        @(negedge clk);
        iMC_done = 1'b0;
        n_cmp++; if (oDEC_en !== 1'b0) begin n_bad++; $display("FAIL stall_done_en got %b want 0", oDEC_en); end
        n_cmp++; if (oMC_en !== 1'b0) begin n_bad++; $display("FAIL stall_hold_mc_en got %b want 0", oMC_en); end
        @(negedge clk);
        n_cmp++; if (oDEC_en !== 1'b0) begin n_bad++; $display("FAIL stall_hold_en got %b want 0", oDEC_en); end
        iDEC_stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (oDEC_en !== 1'b1) begin n_bad++; $display("FAIL stall_release_en got %b want 1", oDEC_en); end
        n_cmp++; if (oDEC_inst !== 32'h00100093) begin n_bad++; $display("FAIL stall_inst got %h want 00100093", oDEC_inst); end
        n_cmp++; if (oDEC_pc !== 32'h18) begin n_bad++; $display("FAIL stall_pc got %h want 18", oDEC_pc); end
        n_cmp++; if (oMC_en !== 1'b1) begin n_bad++; $display("FAIL stall_refetch_en got %b want 1", oMC_en); end
        n_cmp++; if (oMC_addr !== 32'h1C) begin n_bad++; $display("FAIL stall_next_addr got %h want 1c", oMC_addr); end
        @(negedge clk);
        n_cmp++; if (oDEC_en !== 1'b0) begin n_bad++; $display("FAIL stall_single_pulse got %b want 0", oDEC_en); end
    endtask

    task automatic test_drop();
        iROB_jump_en = 1'b1;
        iROB_jump_pc = 32'h100;
        @(negedge clk);
        iROB_jump_en = 1'b0;
        n_cmp++; if (oMC_en !== 1'b1) begin n_bad++; $display("FAIL drop_inflight_en got %b want 1", oMC_en); end
        n_cmp++; if (oMC_addr !== 32'h1C) begin n_bad++; $display("FAIL drop_inflight_addr got %h want 1c", oMC_addr); end
        iMC_done = 1'b1;
        iMC_inst = 32'h0080006F;
        @(negedge clk);
        iMC_done = 1'b0;
        n_cmp++; if (oDEC_en !== 1'b0) begin n_bad++; $display("FAIL drop_data_en got %b want 0", oDEC_en); end
        n_cmp++; if (oMC_addr !== 32'h100) begin n_bad++; $display("FAIL drop_target got %h want 100", oMC_addr); end
        @(negedge clk);
        n_cmp++; if (oDEC_en !== 1'b0) begin n_bad++; $display("FAIL drop_late_en got %b want 0", oDEC_en); end
        iMC_done = 1'b1;
        iMC_inst = 32'h00000013;
        @(negedge clk);
        iMC_done = 1'b0;
        n_cmp++; if (oDEC_pc !== 32'h100) begin n_bad++; $display("FAIL drop_after_pc got %h want 100", oDEC_pc); end
        n_cmp++; if (oMC_addr !== 32'h104) begin n_bad++; $display("FAIL drop_after_addr got %h want 104", oMC_addr); end
    endtask

    task automatic test_hold_redirect();
        iDEC_stall = 1'b1;
        iMC_done   = 1'b1;
        iMC_inst   = 32'h00000013;
        @(negedge clk);
        iMC_done     = 1'b0;
        iROB_jump_en = 1'b1;
        iROB_jump_pc = 32'h200;
        @(negedge clk);
        iROB_jump_en = 1'b0;
        iDEC_stall   = 1'b0;
        n_cmp++; if (oDEC_en !== 1'b0) begin n_bad++; $display("FAIL hold_redir_en got %b want 0", oDEC_en); end
        n_cmp++; if (oMC_addr !== 32'h200) begin n_bad++; $display("FAIL hold_redir_addr got %h want 200", oMC_addr); end
        n_cmp++; if (oMC_en !== 1'b1) begin n_bad++; $display("FAIL hold_redir_mc_en got %b want 1", oMC_en); end
        @(negedge clk);
        n_cmp++; if (oDEC_en !== 1'b0) begin n_bad++; $display("FAIL hold_redir_late got %b want 0", oDEC_en); end
    endtask

    task automatic test_branch();
        goto_pc(32'h20);
        iROB_bp_en    = 1'b1;
        iROB_bp_pc    = 32'h20;
        iROB_bp_taken = 1'b1;
        @(negedge clk);
        @(negedge clk);
        iROB_bp_en = 1'b0;
        iMC_done   = 1'b1;
        iMC_inst   = 32'hFE000CE3;
        @(negedge clk);
        iMC_done = 1'b0;
`ifdef IF_BHT_EN
        n_cmp++; if (oDEC_pd !== 1'b1) begin n_bad++; $display("FAIL beq_trained_pd got %b want 1", oDEC_pd); end
        n_cmp++; if (oMC_addr !== 32'h18) begin n_bad++; $display("FAIL beq_trained_addr got %h want 18", oMC_addr); end
`else
        n_cmp++; if (oDEC_pd !== 1'b0) begin n_bad++; $display("FAIL beq_static_pd got %b want 0", oDEC_pd); end
        n_cmp++; if (oMC_addr !== 32'h24) begin n_bad++; $display("FAIL beq_static_addr got %h want 24", oMC_addr); end
`endif
        n_cmp++; if (oDEC_pc !== 32'h20) begin n_bad++; $display("FAIL beq_pc got %h want 20", oDEC_pc); end
        goto_pc(32'h40);
        iMC_done = 1'b1;
        iMC_inst = 32'hFE000CE3;
        @(negedge clk);
        iMC_done = 1'b0;
        n_cmp++; if (oDEC_pd !== 1'b0) begin n_bad++; $display("FAIL beq_untrained_pd got %b want 0", oDEC_pd); end
        n_cmp++; if (oMC_addr !== 32'h44) begin n_bad++; $display("FAIL beq_untrained_addr got %h want 44", oMC_addr); end
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFFFFFC);
        iMC_done = 1'b1;
        iMC_inst = 32'h00000013;
        @(negedge clk);
        iMC_done = 1'b0;
        n_cmp++; if (oDEC_pc !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL wrap_pc got %h want fffffffc", oDEC_pc); end
        n_cmp++; if (oMC_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr got %h want 0", oMC_addr); end
        iMC_done = 1'b1;
        iMC_inst = 32'hFFDFF06F;
        @(negedge clk);
        iMC_done = 1'b0;
        n_cmp++; if (oDEC_pd !== 1'b1) begin n_bad++; $display("FAIL jal_neg_pd got %b want 1", oDEC_pd); end
        n_cmp++; if (oMC_addr !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL jal_neg_addr got %h want fffffffc", oMC_addr); end
    endtask

    task automatic test_rdy();
        rdy      = 1'b0;
        iMC_done = 1'b1;
        iMC_inst = 32'h00000013;
        @(negedge clk);
        iMC_done = 1'b0;
        rdy      = 1'b1;
        n_cmp++; if (oDEC_en !== 1'b0) begin n_bad++; $display("FAIL rdy_low_en got %b want 0", oDEC_en); end
        n_cmp++; if (oMC_addr !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL rdy_low_addr got %h want fffffffc", oMC_addr); end
        @(negedge clk);
        n_cmp++; if (oDEC_en !== 1'b0) begin n_bad++; $display("FAIL rdy_low_late got %b want 0", oDEC_en); end
    endtask

    task automatic test_reset_mid();
        iDEC_stall = 1'b1;
        iMC_done   = 1'b1;
        iMC_inst   = 32'h00000013;
        @(negedge clk);
        iMC_done = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (oMC_addr !== 32'h0) begin n_bad++; $display("FAIL mid_rst_addr got %h want 0", oMC_addr); end
        n_cmp++; if (oDEC_pc !== 32'h0) begin n_bad++; $display("FAIL mid_rst_dec_pc got %h want 0", oDEC_pc); end
        n_cmp++; if (oDEC_inst !== 32'h0) begin n_bad++; $display("FAIL mid_rst_dec_inst got %h want 0", oDEC_inst); end
        iDEC_stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (oMC_en !== 1'b0) begin n_bad++; $display("FAIL mid_rst_mc_en got %b want 0", oMC_en); end
        @(negedge clk);
        n_cmp++; if (oMC_en !== 1'b1) begin n_bad++; $display("FAIL mid_rst_refetch_en got %b want 1", oMC_en); end
        n_cmp++; if (oMC_addr !== 32'h0) begin n_bad++; $display("FAIL mid_rst_refetch_addr got %h want 0", oMC_addr); end
        n_cmp++; if (oDEC_en !== 1'b0) begin n_bad++; $display("FAIL mid_rst_dec_en got %b want 0", oDEC_en); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_jal();
        test_stall();
        test_drop();
        test_hold_redirect();
        test_branch();
        test_wrap();
        test_rdy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit: owns the architectural fetch PC, requests 32-bit instruction words from the memory controller, and delivers each word to the decoder with its PC and a predicted-jump flag. It sits at the head of the pipeline. It performs static/dynamic next-PC prediction, holds an instruction while the downstream side stalls, and redirects on a ROB misprediction.

## Interface
- RESET_PC, 32'h0, PC fetched after reset.
- BHT_ENTRIES, 64, number of 2-bit counters (power of two); index = pc[log2(BHT_ENTRIES)+1:2].
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable; when 0 every register holds, except oDEC_en, which is forced to 0.
- oMC_en  out  1  fetch request, level, held until iMC_done.
- oMC_addr  out  32  fetch address.
- iMC_done  in  1  one-cycle pulse, iMC_inst valid.
- iMC_inst  in  32  fetched word.
- iDEC_stall  in  1  downstream (RS/ROB/LSB) cannot accept this cycle.
- oDEC_en  out  1  one-cycle pulse, instruction valid to decoder.
- oDEC_inst  out  32  instruction word.
- oDEC_pc  out  32  its PC.
- oDEC_pd  out  1  predicted jump (`Jump`/`NotJump`).
- iROB_jump_en  in  1  misprediction redirect.
- iROB_jump_pc  in  32  correct PC.
- iROB_bp_en  in  1  branch-outcome update (BHT only).
- iROB_bp_pc  in  32  PC of resolved branch.
- iROB_bp_taken  in  1  resolved direction.

## Operation
- States: IDLE, FETCH, HOLD, DROP. Reset state is IDLE.
- IDLE: oMC_en=0; next cycle FETCH at pc.
- FETCH: oMC_en=1, oMC_addr=pc. On iMC_done:
  - If iDEC_stall=0, register the word to the decoder outputs.
  - Otherwise go to HOLD.
  - In both cases, compute next pc.
- HOLD: the word is latched. On the first cycle with iDEC_stall=0, emit oDEC_en and return to FETCH at next pc.
- DROP: a request is in flight but its data is stale. Wait for iMC_done, discard the data, then go to FETCH at the redirect pc.
- Next-PC prediction from the fetched word:
  - opcode 1101111 (JAL): pc + J-imm, pd=Jump.
  - opcode 1100011 (branch): if predicted taken, pc + B-imm with pd=Jump; otherwise pc+4 with pd=NotJump.
  - All others, including JALR: pc+4, pd=NotJump.
- Immediates are sign-extended per RV32I. All PC arithmetic is 32-bit, modulo 2^32 (wraps from 0xFFFFFFFC to 0).
- Redirect (iROB_jump_en) has the highest priority. pc <= iROB_jump_pc, and the pending decoder output is cancelled, so oDEC_en is 0 next cycle.
  - In FETCH without iMC_done: go to DROP.
  - In FETCH with iMC_done in the same cycle: discard the word and go to FETCH.
  - In HOLD: discard the held word and go to FETCH.
  - In DROP: update the target pc and stay in DROP.
  - In IDLE: update pc.
- Reset mid-operation: all state returns to reset values immediately. The memory controller shares rst, so no in-flight completion survives.

## Timing
- Reset values: oMC_en=0, oMC_addr=0, oDEC_en=0, oDEC_inst=0, oDEC_pc=0, oDEC_pd=NotJump, pc=RESET_PC, state=IDLE. BHT counters reset to 2'b01.
- Latency: oDEC_en rises one cycle after iMC_done when not stalled. In that same cycle oMC_en=1 with the next address.
- Stall is sampled in the iMC_done cycle and in each HOLD cycle. No instruction is emitted twice, and none is emitted while iDEC_stall=1.
- iROB_bp_en updates take effect on the next edge. A simultaneous lookup of the same index sees the old counter.

## Configuration
- IF_BHT_EN defined: instantiate the BHT.
  - Branch prediction uses counter[1] (taken when counter[1]=1).
  - Counters saturate at 00 and 11, incrementing on taken and decrementing on not-taken.
- IF_BHT_EN undefined:
  - Branches are always predicted not-taken.
  - iROB_bp_* inputs are ignored.
  - No BHT storage is built.
  - JAL prediction is unchanged.

## Structure
- Shared config.v contents:
  - Opcode constants (OP_JAL, OP_BRANCH).
  - `AddrBus`/`InstBus` widths.
  - `Jump`/`NotJump`.
  - FSM state encodings.
- Sub-module `branch_predictor` (BHT lookup and update), instantiated only under IF_BHT_EN.

## Test plan
- Reset, then iMC_done with 0x00000013 at pc 0 → oMC_addr=0 → oDEC_en pulse with inst 0x13, pc 0, pd=0; next oMC_addr=4.
- JAL 0x0080006F fetched at pc 0x10 → oDEC_pd=1; next oMC_addr=0x18.
- iDEC_stall=1 for 3 cycles around iMC_done → no oDEC_en until stall drops, then exactly one pulse with the held word.
- iROB_jump_en with pc 0x100 while a request is outstanding → the next iMC_done data is dropped, oDEC_en stays 0, then oMC_addr=0x100.
- With IF_BHT_EN: two iROB_bp_en taken updates for BEQ at 0x20 with imm -8 → next fetch of 0x20 gives pd=1 and oMC_addr=0x18. Without the macro: pd=0 and oMC_addr=0x24.
- pc=0xFFFFFFFC with a non-jump word → next oMC_addr=0x00000000.
